// File: rtl/ber_pkg.sv
// Shared types and helpers for the bit-error-rate tracker.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Widest counter the saturating helper handles.
  localparam int SAT_MAX_W = 128;

  // Bits needed to hold values 0..value-1 (at least one bit).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

  // Increment that sticks at all-ones within the low 'width' bits.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int width);
    logic [SAT_MAX_W-1:0] ones;
    ones = (width >= SAT_MAX_W) ? {SAT_MAX_W{1'b1}}
                                : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return ((value & ones) == ones) ? value : (value + SAT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/ber_ref_delay.sv
// Reference delay line: tap k holds the reference bit from k+1 valid
// samples ago. Shifts only on valid samples so stalls are exact.
module ber_ref_delay
  import ber_pkg::*;
#(
  parameter int MAX_LAT = 511,
  parameter int LAT_W   = clog2(MAX_LAT)
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic             i_ref,
  input  logic [LAT_W-1:0] i_sel,
  output logic             o_tap
);

  logic [MAX_LAT-1:0] line_q, line_d;

  // Shift one reference bit in per valid sample.
  always_comb begin
    line_d = line_q;
    if (i_valid) begin
      line_d = MAX_LAT'({line_q, i_ref});
    end
  end

  // Delay line register, cleared by reset.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  // Tap select; selects beyond the line read as zero.
  always_comb begin
    o_tap = 1'b0;
    if (32'(i_sel) < 32'(MAX_LAT)) begin
      o_tap = line_q[i_sel];
    end
  end

endmodule

// File: rtl/ber_tracker.sv
// Bit-error-rate tracker: fills the reference delay line, searches for the
// tap that best matches the received stream, then counts bits and errors
// at that tap while watching each window for loss of sync.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_FILL   | pre-filling the delay line, MAX_LAT valid samples
//   ST_SEARCH | scoring one candidate tap per WIN_LEN-sample window
//   ST_LOCKED | counting bits/errors at o_latency, monitoring windows
module ber_tracker
  import ber_pkg::*;
#(
  parameter int MAX_LAT     = 511,
  parameter int WIN_LEN     = 511,
  parameter int CNT_W       = 64,
  parameter int LOS_THR     = 128,
  parameter int AUTO_RESYNC = 1,
  parameter int LAT_W       = clog2(MAX_LAT),
  parameter int WIN_W       = clog2(WIN_LEN + 1)
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_rx,
  input  logic             i_ref,
  input  logic             i_valid,
  input  logic             i_clear,
  input  logic             i_resync,
  output logic [CNT_W-1:0] o_errors,
  output logic [CNT_W-1:0] o_bits,
  output logic             o_synced,
  output logic [LAT_W-1:0] o_latency,
  output logic [WIN_W-1:0] o_min_error,
  output logic [15:0]      o_los_count
);

  // One down-counter serves the fill phase and every window.
  localparam int CW = (LAT_W > WIN_W) ? LAT_W : WIN_W;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0] cand_q, cand_d;
  logic [LAT_W-1:0] min_lat_q, min_lat_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [WIN_W-1:0] win_err_q, win_err_d;
  logic [WIN_W-1:0] min_err_q, min_err_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic [15:0]      los_q, los_d;

  logic             tap;
  logic             mism;
  logic [LAT_W-1:0] sel;
  logic [LAT_W-1:0] lock_lat;
  logic [WIN_W-1:0] win_tot;
  logic             go_search;
  logic             go_lock;
  logic             new_min;

  // The same delay line serves search (candidate) and lock (chosen tap).
  assign sel     = (state_q == ST_LOCKED) ? lat_q : cand_q;
  assign mism    = tap ^ i_rx;
  assign win_tot = win_err_q + WIN_W'(mism);

  ber_ref_delay #(
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_ref_delay (
    .clock   (clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_ref   (i_ref),
    .i_sel   (sel),
    .o_tap   (tap)
  );

  // Next state: FSM, window scoring, min tracking, BER and LOS counters.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    win_err_d = win_err_q;
    min_err_d = min_err_q;
    min_lat_d = min_lat_q;
    lat_d     = lat_q;
    bits_d    = bits_q;
    errors_d  = errors_q;
    los_d     = los_q;
    go_search = 1'b0;
    go_lock   = 1'b0;
    new_min   = 1'b0;
    lock_lat  = cand_q;

    if (i_resync && (state_q != ST_FILL)) begin
      go_search = 1'b1;
    end else if (i_valid) begin
      case (state_q)
        ST_FILL: begin
          if (cnt_q == '0) begin
            go_search = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_SEARCH: begin
          if (cnt_q != '0) begin
            cnt_d     = cnt_q - CW'(1);
            win_err_d = win_tot;
          end else begin
            // Strict compare so ties keep the lowest tap.
            new_min = (win_tot < min_err_q);
            if (new_min) begin
              min_err_d = win_tot;
              min_lat_d = cand_q;
            end
            if (win_tot == '0) begin
              go_lock  = 1'b1;
              lock_lat = cand_q;
            end else if (cand_q == LAT_W'(MAX_LAT - 1)) begin
              go_lock  = 1'b1;
              lock_lat = new_min ? cand_q : min_lat_q;
            end else begin
              cand_d    = cand_q + LAT_W'(1);
              win_err_d = '0;
              cnt_d     = CW'(WIN_LEN - 1);
            end
          end
        end
        ST_LOCKED: begin
          bits_d = CNT_W'(sat_inc(SAT_MAX_W'(bits_q), CNT_W));
          if (mism) begin
            errors_d = CNT_W'(sat_inc(SAT_MAX_W'(errors_q), CNT_W));
          end
          if (cnt_q != '0) begin
            cnt_d     = cnt_q - CW'(1);
            win_err_d = win_tot;
          end else begin
            cnt_d     = CW'(WIN_LEN - 1);
            win_err_d = '0;
            if (32'(win_tot) > 32'(LOS_THR)) begin
              los_d = 16'(sat_inc(SAT_MAX_W'(los_q), 16));
              if (AUTO_RESYNC != 0) begin
                go_search = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end

    if (go_lock) begin
      state_d   = ST_LOCKED;
      lat_d     = lock_lat;
      cnt_d     = CW'(WIN_LEN - 1);
      win_err_d = '0;
    end

    // A fresh search keeps the delay line contents, so no refill.
    if (go_search) begin
      state_d   = ST_SEARCH;
      cand_d    = '0;
      cnt_d     = CW'(WIN_LEN - 1);
      win_err_d = '0;
      min_err_d = WIN_W'(WIN_LEN);
      min_lat_d = '0;
    end

    // Clear beats any increment in the same cycle.
    if (i_clear) begin
      bits_d   = '0;
      errors_d = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q   <= ST_FILL;
      cnt_q     <= CW'(MAX_LAT - 1);
      cand_q    <= '0;
      min_lat_q <= '0;
      lat_q     <= '0;
      win_err_q <= '0;
      min_err_q <= WIN_W'(WIN_LEN);
      bits_q    <= '0;
      errors_q  <= '0;
      los_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      min_lat_q <= min_lat_d;
      lat_q     <= lat_d;
      win_err_q <= win_err_d;
      min_err_q <= min_err_d;
      bits_q    <= bits_d;
      errors_q  <= errors_d;
      los_q     <= los_d;
    end
  end

  assign o_errors    = errors_q;
  assign o_bits      = bits_q;
  assign o_synced    = (state_q == ST_LOCKED);
  assign o_latency   = lat_q;
  assign o_min_error = min_err_q;
  assign o_los_count = los_q;

endmodule

// File: tb/tb_ber_tracker.sv
// Bench for ber_tracker: three instances share one stimulus stream
// (A: auto resync, B: flag only, C: 4-bit counters). Each is compared every
// cycle against a history-based reference model, plus fixed expectations.
module tb_ber_tracker;

  localparam int ML = 16;
  localparam int WL = 32;
  localparam int LT = 8;
  localparam int M_FILL   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_LOCKED = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic i_reset, i_rx, i_ref, i_valid, i_clear, i_resync;
  logic [63:0] a_errors, a_bits, b_errors, b_bits;
  logic [3:0]  c_errors, c_bits;
  logic        a_synced, b_synced, c_synced;
  logic [3:0]  a_lat, b_lat, c_lat;
  logic [5:0]  a_min, b_min, c_min;
  logic [15:0] a_los, b_los, c_los;

  ber_tracker #(.MAX_LAT(ML), .WIN_LEN(WL), .CNT_W(64), .LOS_THR(LT), .AUTO_RESYNC(1)) dut_a (
    .clock(clock), .i_reset(i_reset), .i_rx(i_rx), .i_ref(i_ref), .i_valid(i_valid),
    .i_clear(i_clear), .i_resync(i_resync), .o_errors(a_errors), .o_bits(a_bits),
    .o_synced(a_synced), .o_latency(a_lat), .o_min_error(a_min), .o_los_count(a_los));

  ber_tracker #(.MAX_LAT(ML), .WIN_LEN(WL), .CNT_W(64), .LOS_THR(LT), .AUTO_RESYNC(0)) dut_b (
    .clock(clock), .i_reset(i_reset), .i_rx(i_rx), .i_ref(i_ref), .i_valid(i_valid),
    .i_clear(i_clear), .i_resync(i_resync), .o_errors(b_errors), .o_bits(b_bits),
    .o_synced(b_synced), .o_latency(b_lat), .o_min_error(b_min), .o_los_count(b_los));

  ber_tracker #(.MAX_LAT(ML), .WIN_LEN(WL), .CNT_W(4), .LOS_THR(LT), .AUTO_RESYNC(1)) dut_c (
    .clock(clock), .i_reset(i_reset), .i_rx(i_rx), .i_ref(i_ref), .i_valid(i_valid),
    .i_clear(i_clear), .i_resync(i_resync), .o_errors(c_errors), .o_bits(c_bits),
    .o_synced(c_synced), .o_latency(c_lat), .o_min_error(c_min), .o_los_count(c_los));

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  // Reference model: per-instance search/lock bookkeeping over a shared
  // history of every valid reference bit since reset.
  bit              m_hist[$];
  int              m_ph[3], m_cnt[3], m_cand[3], m_werr[3], m_best[3], m_bestlat[3];
  int              m_lat[3], m_merr[3], m_los[3];
  longint unsigned m_bits[3], m_errs[3];
  longint unsigned m_cmax[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd15};
  bit              m_auto[3] = '{1'b1, 1'b0, 1'b1};

  // Stimulus side: PRBS7 state and history of sent reference bits.
  logic [6:0] lfsr;
  bit         s_hist[$];

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic bit hist_err(int t, bit rx);
    int idx;
    bit r;
    idx = m_hist.size() - 1 - t;
    r = (idx >= 0) ? m_hist[idx] : 1'b0;
    return r ^ rx;
  endfunction

  task automatic model_search(int k);
    m_ph[k] = M_SEARCH; m_cand[k] = 0; m_cnt[k] = 0; m_werr[k] = 0;
    m_best[k] = WL; m_bestlat[k] = 0;
  endtask

  task automatic model_lock(int k, int lat);
    m_ph[k] = M_LOCKED; m_lat[k] = lat; m_cnt[k] = 0; m_merr[k] = 0;
  endtask

  task automatic model_reset(int k);
    m_ph[k] = M_FILL; m_cnt[k] = 0; m_cand[k] = 0; m_werr[k] = 0; m_best[k] = WL;
    m_bestlat[k] = 0; m_lat[k] = 0; m_merr[k] = 0; m_los[k] = 0; m_bits[k] = 0; m_errs[k] = 0;
  endtask

  task automatic model_step(int k, bit v, bit rx, bit clr, bit rsy);
    bit e;
    if (rsy && m_ph[k] != M_FILL) begin
      model_search(k);
    end else if (v) begin
      case (m_ph[k])
        M_FILL: begin
          m_cnt[k]++;
          if (m_cnt[k] == ML) model_search(k);
        end
        M_SEARCH: begin
          m_werr[k] += int'(hist_err(m_cand[k], rx));
          m_cnt[k]++;
          if (m_cnt[k] == WL) begin
            if (m_werr[k] < m_best[k]) begin
              m_best[k] = m_werr[k];
              m_bestlat[k] = m_cand[k];
            end
            if (m_werr[k] == 0) model_lock(k, m_cand[k]);
            else if (m_cand[k] == ML - 1) model_lock(k, m_bestlat[k]);
            else begin
              m_cand[k]++; m_cnt[k] = 0; m_werr[k] = 0;
            end
          end
        end
        default: begin
          e = hist_err(m_lat[k], rx);
          if (m_bits[k] < m_cmax[k]) m_bits[k]++;
          if (e && m_errs[k] < m_cmax[k]) m_errs[k]++;
          m_merr[k] += int'(e);
          m_cnt[k]++;
          if (m_cnt[k] == WL) begin
            if (m_merr[k] > LT) begin
              if (m_los[k] < 65535) m_los[k]++;
              if (m_auto[k]) model_search(k);
            end
            if (m_ph[k] == M_LOCKED) m_cnt[k] = 0;
            m_merr[k] = 0;
          end
        end
      endcase
    end
    if (clr) begin
      m_bits[k] = 0; m_errs[k] = 0;
    end
  endtask

  task automatic check_model();
    chk("A.errors", a_errors, m_errs[0]);   chk("A.bits", a_bits, m_bits[0]);
    chk("A.synced", a_synced, m_ph[0] == M_LOCKED); chk("A.latency", a_lat, m_lat[0]);
    chk("A.min_error", a_min, m_best[0]);   chk("A.los", a_los, m_los[0]);
    chk("B.errors", b_errors, m_errs[1]);   chk("B.bits", b_bits, m_bits[1]);
    chk("B.synced", b_synced, m_ph[1] == M_LOCKED); chk("B.latency", b_lat, m_lat[1]);
    chk("B.min_error", b_min, m_best[1]);   chk("B.los", b_los, m_los[1]);
    chk("C.errors", c_errors, m_errs[2]);   chk("C.bits", c_bits, m_bits[2]);
    chk("C.synced", c_synced, m_ph[2] == M_LOCKED); chk("C.latency", c_lat, m_lat[2]);
    chk("C.min_error", c_min, m_best[2]);   chk("C.los", c_los, m_los[2]);
  endtask

  task automatic cyc(bit rst, bit v, bit rx, bit rf, bit clr, bit rsy);
    i_reset = rst; i_valid = v; i_rx = rx; i_ref = rf; i_clear = clr; i_resync = rsy;
    @(posedge clock);
    #1;
    ncyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) model_reset(k);
      m_hist.delete();
    end else begin
      for (int k = 0; k < 3; k++) model_step(k, v, rx, clr, rsy);
      if (v) m_hist.push_back(rf);
    end
    check_model();
  endtask

  task automatic drive(int dly, bit rnd, bit v, bit inv, bit clr, bit rsy);
    bit rf, rx, nb;
    if (v) begin
      if (rnd) rf = 1'($urandom);
      else begin
        nb = lfsr[6] ^ lfsr[5];
        lfsr = {lfsr[5:0], nb};
        rf = nb;
      end
      rx = (s_hist.size() >= dly) ? s_hist[s_hist.size() - dly] : 1'b0;
      rx = rx ^ inv;
      s_hist.push_back(rf);
    end else begin
      rf = 1'($urandom);
      rx = 1'($urandom);
    end
    cyc(1'b0, v, rx, rf, clr, rsy);
  endtask

  task automatic do_reset(bit v);
    s_hist.delete();
    lfsr = 7'h7F;
    cyc(1'b1, v, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_a_errors", a_errors, 0); chk("rst_a_bits", a_bits, 0);
    chk("rst_a_synced", a_synced, 0); chk("rst_a_latency", a_lat, 0);
    chk("rst_a_min_error", a_min, WL); chk("rst_a_los", a_los, 0);
    chk("rst_c_bits", c_bits, 0);     chk("rst_b_min_error", b_min, WL);
  endtask

  typedef struct {
    bit rst, v, rx, rf, clr, rsy;
    bit exp_synced;
    int exp_min;
    int exp_bits;
    int exp_los;
  } vec_t;

  vec_t vt[6];
  int   n;
  bit   rv;
  int   inv_div;

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_rx = 1'b0; i_ref = 1'b0; i_clear = 1'b0; i_resync = 1'b0;
    lfsr = 7'h7F;

    // Reset and FILL-phase behaviour: resync/clear ignored, outputs at reset values.
    vt[0] = '{rst:1, v:0, rx:0, rf:0, clr:0, rsy:0, exp_synced:0, exp_min:WL, exp_bits:0, exp_los:0};
    vt[1] = '{rst:0, v:1, rx:1, rf:0, clr:0, rsy:1, exp_synced:0, exp_min:WL, exp_bits:0, exp_los:0};
    vt[2] = '{rst:0, v:1, rx:0, rf:1, clr:1, rsy:0, exp_synced:0, exp_min:WL, exp_bits:0, exp_los:0};
    vt[3] = '{rst:0, v:0, rx:1, rf:1, clr:0, rsy:1, exp_synced:0, exp_min:WL, exp_bits:0, exp_los:0};
    vt[4] = '{rst:0, v:1, rx:1, rf:1, clr:0, rsy:0, exp_synced:0, exp_min:WL, exp_bits:0, exp_los:0};
    vt[5] = '{rst:1, v:1, rx:1, rf:1, clr:0, rsy:1, exp_synced:0, exp_min:WL, exp_bits:0, exp_los:0};
    for (int i = 0; i < 6; i++) begin
      cyc(vt[i].rst, vt[i].v, vt[i].rx, vt[i].rf, vt[i].clr, vt[i].rsy);
      chk($sformatf("vec%0d_synced", i), a_synced, vt[i].exp_synced);
      chk($sformatf("vec%0d_min_error", i), a_min, vt[i].exp_min);
      chk($sformatf("vec%0d_bits", i), a_bits, vt[i].exp_bits);
      chk($sformatf("vec%0d_los", i), a_los, vt[i].exp_los);
    end

    // PRBS7, rx delayed 5: lock at tap 4 after 16 + 5*32 samples.
    do_reset(1'b0);
    for (int k = 1; k <= 176; k++) begin
      drive(5, 0, 1, 0, 0, 0);
      if (k == 175) chk("prelock_synced", a_synced, 0);
    end
    chk("lock_synced", a_synced, 1);
    chk("lock_latency", a_lat, 4);
    chk("lock_min_error", a_min, 0);
    repeat (1000) drive(5, 0, 1, 0, 0, 0);
    chk("clean_bits", a_bits, 1000);
    chk("clean_errors", a_errors, 0);
    chk("sat4_bits_clean", c_bits, 15);

    // Clear with a valid sample: that sample is not counted.
    drive(5, 0, 1, 0, 1, 0);
    chk("clear_bits", a_bits, 0);
    chk("clear_errors", a_errors, 0);
    chk("clear_synced", a_synced, 1);
    for (int k = 1; k <= 1000; k++) drive(5, 0, 1, (k % 10) == 0, 0, 0);
    chk("inv10_errors", a_errors, 100);
    chk("inv10_bits", a_bits, 1000);
    chk("inv10_synced", a_synced, 1);
    chk("inv10_los", a_los, 0);
    chk("sat4_errors_inv", c_errors, 15);

    // Forced resync: counters held, relock at tap 4 after 5 windows.
    drive(5, 0, 1, 0, 0, 1);
    chk("resync_synced", a_synced, 0);
    chk("resync_bits_held", a_bits, 1000);
    chk("resync_errors_held", a_errors, 100);
    repeat (160) drive(5, 0, 1, 0, 0, 0);
    chk("relock_synced", a_synced, 1);
    chk("relock_latency", a_lat, 4);

    // Random 50% valid: same end result as the continuous run.
    do_reset(1'b0);
    n = 0;
    for (int c = 0; c < 20000 && n < 1176; c++) begin
      rv = 1'($urandom);
      drive(5, 0, rv, 0, 0, 0);
      if (rv) n++;
    end
    chk("stall_samples", n, 1176);
    chk("stall_bits", a_bits, 1000);
    chk("stall_errors", a_errors, 0);
    chk("stall_latency", a_lat, 4);
    chk("stall_synced", a_synced, 1);

    // Delay 20 (no matching tap): full search, lock at best tap, then LOS.
    do_reset(1'b0);
    repeat (ML + ML * WL) drive(20, 1, 1, 0, 0, 0);
    chk("full_search_synced", a_synced, 1);
    chk("full_search_latency", a_lat, m_lat[0]);
    repeat (WL) drive(20, 1, 1, 0, 0, 0);
    chk("noauto_synced", b_synced, 1);
    repeat (2 * WL) drive(20, 1, 1, 0, 0, 0);
    chk("noauto_synced_late", b_synced, 1);
    chk("noauto_los", b_los, m_los[1]);

    // Saturation of 4-bit counters, then reset in the middle of a search.
    do_reset(1'b0);
    repeat (176) drive(5, 0, 1, 0, 0, 0);
    repeat (40) drive(5, 0, 1, 1, 0, 0);
    chk("sat4_bits", c_bits, 15);
    chk("sat4_errors", c_errors, 15);
    chk("auto_los_count", a_los, 1);
    chk("auto_los_synced", a_synced, 0);
    repeat (10) drive(5, 0, 1, 0, 0, 0);
    do_reset(1'b1);

    // Random soak: valid gaps, sparse clears and resyncs, error bursts.
    for (int c = 0; c < 3000; c++) begin
      inv_div = (c >= 1500 && c < 2000) ? 2 : 40;
      drive(5, 0, ($urandom_range(0, 3) != 0), ($urandom_range(0, inv_div - 1) == 0),
            ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
